core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Parametrised shared-DRAM arbiter and completion barrier for a cluster of NUM_CORES processor cores.
- Sits between the cores' DRAM request ports and one single-port DRAM.
- Grants one core per transaction in round-robin order and returns read data after the DRAM's read latency.
- Drives each core's 2-bit status input and collects end_process into a cluster-wide done flag.
- Successor to the fixed two-core status/end_core wiring; generalises core count, data/address width and read latency.

Parameters:
NUM_CORES, 4, number of attached cores (2..16)
DATA_W, 16, DRAM data width
ADDR_W, 16, DRAM address width
RD_LAT, 1, DRAM read latency in cycles (1..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
core_en  in  NUM_CORES  cores taking part in the run; sampled only in IDLE
start  in  1  pulse; clears done mask, begins run
req  in  NUM_CORES  per-core access request; held until ack
wren  in  NUM_CORES  per-core write (1) / read (0)
addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CORES*DATA_W  per-core write data
end_process  in  NUM_CORES  per-core completion level
ack  out  NUM_CORES  one-hot pulse: write accepted, or read data valid
rdata  out  DATA_W  read data, broadcast; valid with ack
status  out  NUM_CORES*2  per-core status: 00 idle, 01 running, 10 waiting on memory, 11 done
mem_addr  out  ADDR_W  DRAM address
mem_wdata  out  DATA_W  DRAM write data
mem_wren  out  1  DRAM write enable
mem_rdata  in  DATA_W  DRAM read data
all_done  out  1  all enabled cores done

Behaviour:
- Reset: FSM=IDLE; rr_ptr=0; done_mask=0; ack=0; mem_wren=0; mem_addr=0; mem_wdata=0; rdata=0; all_done=0; status=all 00.
- FSM states:
  - IDLE: waits for start. On start, latch core_en into en_mask, clear done_mask, go to ARB.
  - ARB: pick the first core i with req[i] & en_mask[i] & ~done_mask[i], searching from rr_ptr upward with wrap-around. Register its index, address and data onto the mem_* outputs.
    - Write: mem_wren=1 for exactly one cycle; ack[i]=1 in the same cycle; rr_ptr=i+1 mod NUM_CORES; stay in ARB.
    - Read: mem_wren=0; go to RWAIT with counter=RD_LAT.
    - No eligible request: stay in ARB.
  - RWAIT: counter decrements each cycle. At 0, capture mem_rdata into rdata and pulse ack[i] for one cycle, then rr_ptr=i+1 mod NUM_CORES and return to ARB.
- Throughput: one write per cycle; one read per RD_LAT+1 cycles. A core must deassert req the cycle after ack or it is re-arbitrated as a new request.
- rdata holds its last value between acks.
- Barrier:
  - done_mask[i] sets on the first cycle end_process[i] & en_mask[i] is 1, and stays sticky until start.
  - A core in done_mask is never granted.
  - all_done=1 the cycle after done_mask == en_mask, and holds until start or rst.
  - In the ARB→done transition, all_done=1 returns the FSM to IDLE; no in-flight read exists there.
- status[i]:
  - 00 when not in en_mask or FSM=IDLE.
  - 11 when done_mask[i].
  - 10 while req[i] and not yet acked.
  - 01 otherwise.
- Boundaries:
  - en_mask=0 at start: all_done=1 next cycle, FSM back to IDLE.
  - end_process[i] while core i's read is in flight: the read completes and acks, then the done bit applies.
  - start while not in IDLE: ignored.
  - rst mid-read: the read is abandoned; no ack is issued.
  - rr_ptr wraps from NUM_CORES-1 to 0.

Decomposition:
- Shared package: status encodings (ST_IDLE, ST_RUN, ST_WAIT, ST_DONE) and FSM state encodings.
- One sub-module, rr_pick: combinational round-robin priority encoder (request vector + pointer → one-hot grant + index). It is reused later for the IRAM arbiter.

Test Plan:
- Reset, then start with core_en=4'b1111, no requests → all status=01, ack=0, mem_wren=0, all_done=0.
- Cores 0 and 2 request a write in the same cycle (addr 0x0010/0x0020, data 0x1111/0x2222), rr_ptr=0 → core 0 acks first, core 2 acks on the next cycle; DRAM sees both writes in that order.
- RD_LAT=2, core 1 reads 0x0005 with DRAM returning 0xBEEF → ack[1] and rdata=0xBEEF exactly 3 cycles after grant; status[1]=10 until the ack.
- All four cores hold read requests continuously → grant order 0,1,2,3,0; no core starved after wrap.
- core_en=4'b0101; end_process[0] rises, then end_process[2] three cycles later → all_done rises one cycle after the second; end_process[1] is ignored; the next start clears all_done.
- Assert rst during RWAIT → no ack; outputs at reset values; a new start works normally.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// core_mem_arbiter_pkg: status and FSM encodings shared by the DRAM arbiter and its picker.
package core_mem_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_WAIT = 2'b10, ST_DONE = 2'b11} core_status_t;
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_RWAIT} arb_state_t;
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first request at or above i_ptr with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    logic [IW-1:0] w_pos;
    always_comb begin
        w_pos   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        // Scan farthest-first so the candidate nearest the pointer is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
        o_gnt = o_valid ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin shared-DRAM arbiter with a cluster-wide completion barrier.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        i_core_en,
    input  logic                        i_start,
    input  logic [NUM_CORES-1:0]        i_req,
    input  logic [NUM_CORES-1:0]        i_wren,
    input  logic [NUM_CORES*ADDR_W-1:0] i_addr,
    input  logic [NUM_CORES*DATA_W-1:0] i_wdata,
    input  logic [NUM_CORES-1:0]        i_end_process,
    output logic [NUM_CORES-1:0]        o_ack,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NUM_CORES*2-1:0]      o_status,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    output logic                        o_mem_wren,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic                        o_all_done
);
    localparam int IW = $clog2(NUM_CORES);

    arb_state_t           r_state, w_next;
    logic [IW-1:0]        r_rr_ptr, r_idx, w_idx;
    logic [NUM_CORES-1:0] r_en_mask, r_done_mask, r_ack, w_elig, w_gnt;
    logic [1:0]           r_cnt;
    logic                 r_all_done, r_mem_wren, w_valid, w_fin, w_issue, w_sel_wren;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata, r_rdata;

    // The core acked this cycle is masked so a request dropped on the ack edge is not granted twice.
    assign w_elig     = i_req & r_en_mask & ~r_done_mask & ~r_ack;
    assign w_fin      = r_done_mask == r_en_mask;
    assign w_issue    = r_state == S_ARB && !w_fin && w_valid;
    assign w_sel_wren = i_wren[w_idx];

    rr_pick #(.N(NUM_CORES)) u_pick (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_ARB : S_IDLE;
            S_ARB:   w_next = w_fin ? S_IDLE : (w_issue && !w_sel_wren) ? S_RWAIT : S_ARB;
            S_RWAIT: w_next = (r_cnt == 2'd0) ? S_ARB : S_RWAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_en_mask   <= '0;
            r_done_mask <= '0;
            r_ack       <= '0;
            r_cnt       <= '0;
            r_all_done  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_state    <= w_next;
            r_ack      <= '0;
            r_mem_wren <= 1'b0;
            if (r_state == S_IDLE && i_start) begin
                r_en_mask   <= i_core_en;
                r_done_mask <= '0;
                r_all_done  <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_done_mask <= r_done_mask | (i_end_process & r_en_mask);
            end
            if (r_state == S_ARB && w_fin)
                r_all_done <= 1'b1;
            if (w_issue) begin
                r_idx       <= w_idx;
                r_mem_addr  <= i_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                r_mem_wdata <= i_wdata[int'(w_idx)*DATA_W +: DATA_W];
                r_mem_wren  <= w_sel_wren;
                r_cnt       <= 2'(RD_LAT - 1);
                if (w_sel_wren) begin
                    r_ack    <= w_gnt;
                    r_rr_ptr <= IW'(rr_next(int'(w_idx), NUM_CORES));
                end
            end
            if (r_state == S_RWAIT) begin
                r_cnt <= r_cnt - 2'd1;
                if (r_cnt == 2'd0) begin
                    r_rdata  <= i_mem_rdata;
                    r_ack    <= NUM_CORES'(1) << r_idx;
                    r_rr_ptr <= IW'(rr_next(int'(r_idx), NUM_CORES));
                end
            end
        end
    end

    always_comb begin
        o_status = '0;
        for (int k = 0; k < NUM_CORES; k++)
            o_status[2*k +: 2] = (!r_en_mask[k] || r_state == S_IDLE) ? ST_IDLE :
                                 r_done_mask[k] ? ST_DONE :
                                 (i_req[k] && !r_ack[k]) ? ST_WAIT : ST_RUN;
    end

    assign o_ack       = r_ack;
    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wren  = r_mem_wren;
    assign o_all_done  = r_all_done;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed plan steps followed by random traffic against a transaction-level model.
module tb_core_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] core_en = '0, req = '0, wren = '0, end_process = '0;
    logic start = 1'b0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0] ack;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic mem_wren, all_done;
    logic [2*N-1:0] status;

    logic [DW-1:0] dram [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] rq;
    logic pl_en = 1'b0;
    logic [7:0] pl_a = '0;
    logic [DW-1:0] pl_d = '0;
    int n_cmp = 0, n_err = 0, cyc = 0;

    core_mem_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_core_en     (core_en),
        .i_start       (start),
        .i_req         (req),
        .i_wren        (wren),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .i_end_process (end_process),
        .o_ack         (ack),
        .o_rdata       (rdata),
        .o_status      (status),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_wren    (mem_wren),
        .i_mem_rdata   (mem_rdata),
        .o_all_done    (all_done)
    );

    always #5 clk = ~clk;

    // DRAM with one output register stage: with RD_LAT=2 data lands one cycle after the address.
    always @(posedge clk) begin
        if (mem_wren) dram[mem_addr[7:0]] <= mem_wdata;
        else if (pl_en) dram[pl_a] <= pl_d;
        rq <= dram[mem_addr[7:0]];
    end
    assign mem_rdata = rq;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order [5];
        int w, last_a, c, d, e, k, m_ptr;
        logic [N-1:0] out_q, acked_now;
        int st [N];
        logic rw [N];
        logic [7:0] ra [N];
        logic [DW-1:0] rd [N];
        order = '{0, 1, 2, 3, 0};
        out_q = '0;

        pl_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pl_a = 8'(i);
            pl_d = (i == 5) ? 16'hBEEF : (i >= 8'h40 && i < 8'h44) ? 16'(16'hA000 + i - 8'h40) : 16'($urandom);
            ref_mem[i] = pl_d;
            tick();
        end
        pl_en = 1'b0;

        chk("rst_ack", ack, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_all_done", all_done, 0);
        chk("rst_status", status, 0);

        rst = 1'b0;
        core_en = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_status", status, 8'h55);
        chk("run_ack", ack, 0);
        chk("run_wren", mem_wren, 0);
        chk("run_all_done", all_done, 0);

        req = 4'b0101;
        wren = 4'b0101;
        addr[0*AW +: AW] = 16'h0010;
        addr[2*AW +: AW] = 16'h0020;
        wdata[0*DW +: DW] = 16'h1111;
        wdata[2*DW +: DW] = 16'h2222;
        tick();
        chk("wr0_ack", ack, 4'b0001);
        chk("wr0_wren", mem_wren, 1);
        chk("wr0_addr", mem_addr, 16'h0010);
        chk("wr0_data", mem_wdata, 16'h1111);
        chk("wr0_status", status, 8'h65);
        req[0] = 1'b0;
        tick();
        chk("wr2_ack", ack, 4'b0100);
        chk("wr2_wren", mem_wren, 1);
        chk("wr2_addr", mem_addr, 16'h0020);
        chk("wr2_data", mem_wdata, 16'h2222);
        req[2] = 1'b0;
        tick();
        chk("wr_idle_ack", ack, 0);
        chk("wr_idle_wren", mem_wren, 0);
        chk("dram_0010", dram[8'h10], 16'h1111);
        chk("dram_0020", dram[8'h20], 16'h2222);
        ref_mem[8'h10] = 16'h1111;
        ref_mem[8'h20] = 16'h2222;

        req = 4'b0010;
        wren = '0;
        addr[1*AW +: AW] = 16'h0005;
        tick();
        chk("rd1_c1_ack", ack, 0);
        chk("rd1_c1_status", status[3:2], 2'b10);
        chk("rd1_addr", mem_addr, 16'h0005);
        chk("rd1_wren", mem_wren, 0);
        tick();
        chk("rd1_c2_ack", ack, 0);
        chk("rd1_c2_status", status[3:2], 2'b10);
        tick();
        chk("rd1_ack", ack, 4'b0010);
        chk("rd1_rdata", rdata, 16'hBEEF);
        chk("rd1_status_after", status[3:2], 2'b01);
        req = '0;
        tick();
        chk("rdata_hold", rdata, 16'hBEEF);
        chk("rdata_hold_ack", ack, 0);

        req = 4'b1000;
        wren = 4'b1000;
        addr[3*AW +: AW] = 16'h0030;
        wdata[3*DW +: DW] = 16'h3333;
        tick();
        chk("wr3_ack", ack, 4'b1000);
        ref_mem[8'h30] = 16'h3333;

        wren = '0;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 16'(16'h0040 + i);
        req = 4'hF;
        last_a = 0;
        for (int i = 0; i < 5; i++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (ack == '0 && w < 8);
            chk("rr_wrap_ack", ack, 32'(1 << order[i]));
            chk("rr_wrap_rdata", rdata, ref_mem[8'h40 + order[i]]);
            if (i > 0) chk("rd_spacing", cyc - last_a, RL + 1);
            last_a = cyc;
        end
        req = '0;

        core_en = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", status, 8'h55);
        end_process = 4'hF;
        tick();
        chk("all_end_status", status, 8'hFF);
        chk("all_end_done0", all_done, 0);
        tick();
        chk("all_end_done1", all_done, 1);
        chk("all_end_idle", status, 0);
        end_process = '0;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bar_start_done", all_done, 0);
        chk("bar_start_status", status, 8'h11);
        end_process = 4'b0011;
        tick();
        chk("bar_c0_status", status, 8'h13);
        chk("bar_c0_done", all_done, 0);
        req = 4'b0001;
        tick();
        chk("done_core_no_grant_a", ack, 0);
        tick();
        chk("done_core_no_grant_b", ack, 0);
        end_process = 4'b0111;
        tick();
        chk("bar_c2_status", status, 8'h33);
        chk("bar_c2_done0", all_done, 0);
        chk("done_core_no_grant_c", ack, 0);
        tick();
        chk("bar_c2_done1", all_done, 1);
        req = '0;
        end_process = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_clears_done", all_done, 0);

        end_process = 4'b0101;
        tick();
        tick();
        chk("pre_empty_done", all_done, 1);
        end_process = '0;
        core_en = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_done0", all_done, 0);
        tick();
        chk("empty_done1", all_done, 1);
        chk("empty_status", status, 0);

        core_en = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        req = 4'b0100;
        wren = '0;
        addr[2*AW +: AW] = 16'h0041;
        tick();
        chk("rstrd_wait", status[5:4], 2'b10);
        rst = 1'b1;
        #1;
        chk("rstrd_ack", ack, 0);
        chk("rstrd_addr", mem_addr, 0);
        chk("rstrd_status", status, 0);
        chk("rstrd_rdata", rdata, 0);
        chk("rstrd_all_done", all_done, 0);
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstrd_no_ack", ack, 0);
        end
        core_en = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        req = 4'b0010;
        wren = 4'b0010;
        addr[1*AW +: AW] = 16'h0050;
        wdata[1*DW +: DW] = 16'h5555;
        tick();
        chk("post_rst_wr_ack", ack, 4'b0010);
        chk("post_rst_wr_addr", mem_addr, 16'h0050);
        ref_mem[8'h50] = 16'h5555;
        req = 4'b0100;
        wren = '0;
        tick();
        tick();
        tick();
        chk("post_rst_rd_ack", ack, 4'b0100);
        chk("post_rst_rd_data", rdata, ref_mem[8'h41]);
        req = '0;

        m_ptr = 3;
        for (int it = 0; it < 700; it++) begin
            tick();
            acked_now = '0;
            if (ack != '0) begin
                chk("rand_onehot", $countones(ack), 1);
                c = 0;
                for (int j = 0; j < N; j++) if (ack[j]) c = j;
                chk("rand_outstanding", out_q[c], 1);
                d = rw[c] ? cyc : cyc - RL;
                e = -1;
                for (int j = 0; j < N; j++) begin
                    k = (m_ptr + j) % N;
                    if (e < 0 && out_q[k] && st[k] <= d - 1) e = k;
                end
                chk("rand_rr_order", c, e);
                chk("rand_latency", (cyc - st[c]) <= 40, 1);
                if (rw[c]) begin
                    chk("rand_wr_en", mem_wren, 1);
                    chk("rand_wr_addr", mem_addr, 16'(ra[c]));
                    chk("rand_wr_data", mem_wdata, rd[c]);
                    ref_mem[ra[c]] = rd[c];
                end else begin
                    chk("rand_rd_data", rdata, ref_mem[ra[c]]);
                end
                m_ptr = (c + 1) % N;
                out_q[c] = 1'b0;
                req[c] = 1'b0;
                acked_now[c] = 1'b1;
            end
            if (it < 600) begin
                for (int j = 0; j < N; j++) begin
                    if (!out_q[j] && !acked_now[j] && $urandom_range(0, 3) == 0) begin
                        out_q[j] = 1'b1;
                        st[j] = cyc;
                        rw[j] = 1'($urandom_range(0, 1));
                        ra[j] = 8'(8'h80 + $urandom_range(0, 15));
                        rd[j] = 16'($urandom);
                        wren[j] = rw[j];
                        addr[j*AW +: AW] = 16'(ra[j]);
                        wdata[j*DW +: DW] = rd[j];
                        req[j] = 1'b1;
                    end
                end
            end
        end
        chk("rand_drained", out_q, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
